// File: rtl/breathing_led_array_if.sv
// Control/LED bundle for breathing_led_array: per-channel enables and restart in,
// PWM drive and frame strobe out.
interface breathing_led_array_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] en;
  logic              restart;
  logic [NUM_CH-1:0] led;
  logic              frame_tick;

  modport master (output en, restart, input  led, frame_tick);
  modport slave  (input  en, restart, output led, frame_tick);
endinterface

// File: rtl/breathing_led_array.sv
// Multi-channel breathing-LED PWM engine: shared prescaler/PWM counter, per-channel triangle ramps.
// Optional BREATHING_LED_GAMMA_EN selects a square-law duty mapping instead of linear.

module breathing_led_ch #(
  parameter int LEVEL_W = 10,
  parameter int INIT_P  = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               restart,
  input  logic               frame_end,
  input  logic               en,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               led
);
  localparam int LEVELS = 1 << LEVEL_W;
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVELS - 1);
  // Ramp position folded onto the triangle: second half of the cycle runs downward.
  localparam logic [LEVEL_W-1:0] INIT_LVL = (INIT_P < LEVELS) ? LEVEL_W'(INIT_P)
                                                              : LEVEL_W'(2*LEVELS - 1 - INIT_P);
  localparam logic               INIT_DIR = (INIT_P >= LEVELS);

  logic [LEVEL_W-1:0] level;
  logic               dir;
  logic [LEVEL_W-1:0] duty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level <= INIT_LVL;
      dir   <= INIT_DIR;
    end else if (restart) begin
      level <= INIT_LVL;
      dir   <= INIT_DIR;
    end else if (frame_end) begin
      if (!dir) begin
        if (level == LVL_MAX) dir   <= 1'b1;
        else                  level <= level + 1'b1;
      end else begin
        if (level == '0)      dir   <= 1'b0;
        else                  level <= level - 1'b1;
      end
    end
  end

`ifdef BREATHING_LED_GAMMA_EN
  logic [2*LEVEL_W-1:0] sq;
  assign sq   = {{LEVEL_W{1'b0}}, level} * {{LEVEL_W{1'b0}}, level};
  assign duty = sq[2*LEVEL_W-1:LEVEL_W];
`else
  assign duty = level;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        led <= 1'b0;
    else if (restart) led <= 1'b0;
    else              led <= en && (pwm_cnt < duty);
  end
endmodule

module breathing_led_array #(
  parameter int NUM_CH     = 2,
  parameter int DIV        = 100,
  parameter int LEVEL_W    = 10,
  parameter int PHASE_STEP = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  breathing_led_array_if.slave   bus
);
  localparam int LEVELS = 1 << LEVEL_W;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0]   cnt_div;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic               tick, frame_end, frame_tick_q;
  logic [NUM_CH-1:0]  led_q;

  assign tick      = (cnt_div == DIV_W'(DIV - 1));
  assign frame_end = tick && (pwm_cnt == LEVEL_W'(LEVELS - 1));

  // pwm_cnt is exactly LEVEL_W wide, so it wraps at LEVELS on its own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_div      <= '0;
      pwm_cnt      <= '0;
      frame_tick_q <= 1'b0;
    end else if (bus.restart) begin
      cnt_div      <= '0;
      pwm_cnt      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_div      <= tick ? '0 : cnt_div + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      frame_tick_q <= frame_end;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    breathing_led_ch #(
      .LEVEL_W (LEVEL_W),
      .INIT_P  ((i * PHASE_STEP) % (2 * LEVELS))
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .restart   (bus.restart),
      .frame_end (frame_end),
      .en        (bus.en[i]),
      .pwm_cnt   (pwm_cnt),
      .led       (led_q[i])
    );
  end

  assign bus.led        = led_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_breathing_led_array.sv
// Directed bench for breathing_led_array at NUM_CH=2, DIV=2, LEVEL_W=2, PHASE_STEP=4.
module tb_breathing_led_array;
  localparam int NUM_CH = 2, DIV = 2, LEVEL_W = 2, PHASE_STEP = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  breathing_led_array_if #(.NUM_CH(NUM_CH)) bus();
  breathing_led_array #(.NUM_CH(NUM_CH), .DIV(DIV), .LEVEL_W(LEVEL_W), .PHASE_STEP(PHASE_STEP))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Expected LED-high clocks per frame (8 clk per frame).
`ifdef BREATHING_LED_GAMMA_EN
  int hi0 [8] = '{0, 0, 2, 4, 4, 2, 0, 0};
  int hi1 [8] = '{4, 2, 0, 0, 0, 0, 2, 4};
`else
  int hi0 [8] = '{0, 2, 4, 6, 6, 4, 2, 0};
  int hi1 [8] = '{6, 4, 2, 0, 0, 2, 4, 6};
`endif

  // Reference timeline: edges since the block was last in its init state.
  int cyc;
  logic [1:0] en_q;
  always @(posedge clk or negedge rstn) begin
    if (!rstn)            cyc <= 0;
    else if (bus.restart) cyc <= 0;
    else                  cyc <= cyc + 1;
  end
  always @(posedge clk) en_q <= bus.en;

  function automatic logic [1:0] exp_led(input int c, input logic [1:0] eq);
    int s, p, f;
    logic [1:0] r;
    r = 2'b00;
    if (c > 0) begin
      s = c - 1;
      p = (s / 2) % 4;
      f = (s / 8) % 8;
      r[0] = eq[0] && (p * 2 < hi0[f]);
      r[1] = eq[1] && (p * 2 < hi1[f]);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en = 2'b11;
    bus.restart = 1'b0;
    rstn = 1'b0;
    repeat (2) step();
    #2 rstn = 1'b1;
  endtask

  task automatic measure_frame(output int h0, output int h1, output int len, output bit to);
    h0 = 0; h1 = 0; len = 0; to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      len++;
      h0 += int'(bus.led[0]);
      h1 += int'(bus.led[1]);
      if (bus.frame_tick) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_frames(input string name, input int nfr);
    int h0, h1, len;
    bit to;
    for (int f = 0; f < nfr; f++) begin
      measure_frame(h0, h1, len, to);
      checks++;
      if (to || len != 8 || h0 != hi0[f % 8] || h1 != hi1[f % 8]) begin
        failures++;
        $display("FAIL %s frame %0d: got len=%0d hi0=%0d hi1=%0d to=%0b, need len=8 hi0=%0d hi1=%0d",
                 name, f, len, h0, h1, to, hi0[f % 8], hi1[f % 8]);
      end
    end
  endtask

  task automatic test_reset();
    bus.en = 2'b11;
    bus.restart = 1'b0;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.led !== 2'b00 || bus.frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: led=%b ft=%b, need led=00 ft=0", bus.led, bus.frame_tick);
      end
    end
    #2 rstn = 1'b1;
    step();
    checks++;
    if (bus.led !== 2'b10 || bus.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_first: led=%b ft=%b, need led=10 ft=0", bus.led, bus.frame_tick);
    end
  endtask

  task automatic test_frame_tick();
    int h0, h1, len;
    bit to;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      measure_frame(h0, h1, len, to);
      checks++;
      if (to || len != 8) begin
        failures++;
        $display("FAIL frame_period %0d: got %0d clk (timeout=%0b), need 8", f, len, to);
      end
    end
  endtask

  task automatic test_breathe();
    do_reset();
    check_frames("breathe", 16);
  endtask

  task automatic test_enable();
    logic [1:0] e;
    do_reset();
    check_frames("enable_pre", 2);
    repeat (3) step();
    bus.en = 2'b10;
    for (int k = 0; k < 24; k++) begin
      step();
      e = exp_led(cyc, en_q);
      checks++;
      if (bus.led !== e || bus.led[0] !== 1'b0) begin
        failures++;
        $display("FAIL enable_off cyc %0d: led=%b, need %b", cyc, bus.led, e);
      end
    end
    bus.en = 2'b11;
    for (int k = 0; k < 40; k++) begin
      step();
      e = exp_led(cyc, en_q);
      checks++;
      if (bus.led !== e) begin
        failures++;
        $display("FAIL enable_resume cyc %0d: led=%b, need %b", cyc, bus.led, e);
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    repeat (11) step();
    bus.restart = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.led !== 2'b00 || bus.frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL restart_hold %0d: led=%b ft=%b, need 00/0", k, bus.led, bus.frame_tick);
      end
    end
    bus.restart = 1'b0;
    check_frames("restart", 8);
    // single-cycle pulse mid-frame
    repeat (5) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    checks++;
    if (bus.led !== 2'b00 || bus.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL restart_pulse: led=%b ft=%b, need 00/0", bus.led, bus.frame_tick);
    end
    check_frames("restart_pulse", 8);
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (25) step();
    checks++;
    if (bus.led !== 2'b01) begin
      failures++;
      $display("FAIL async_pre: led=%b, need 01", bus.led);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus.led !== 2'b00 || bus.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL async_led: led=%b ft=%b, need 00/0", bus.led, bus.frame_tick);
    end
    step();
    #2 rstn = 1'b1;
    repeat (8) step();
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL async_ft_pre: ft=%b, need 1", bus.frame_tick);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus.frame_tick !== 1'b0 || bus.led !== 2'b00) begin
      failures++;
      $display("FAIL async_ft: led=%b ft=%b, need 00/0", bus.led, bus.frame_tick);
    end
    step();
    #2 rstn = 1'b1;
    check_frames("async_after", 8);
  endtask

  initial begin
    bus.en = 2'b11;
    bus.restart = 1'b0;
    test_reset();
    test_frame_tick();
    test_breathe();
    test_enable();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
